// File: rtl/booth_seq_divider.sv
// booth_seq_divider: sequential signed divider, one quotient bit per clock.
// Restoring division on operand magnitudes, followed by a single sign-fix cycle.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
// Optional feature: define DIV_OVF_FLAG_EN to add the 'ovf' output, which flags
// the one overflowing case, -2^(WIDTH-1) / -1.
module booth_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef DIV_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg;      // holds |dividend| initially, quotient bits shift in
    logic [WIDTH-1:0] rem_reg;    // partial remainder, always < |divisor|
    logic [WIDTH:0]   dmag;       // |divisor|, one extra bit so -2^(W-1) is exact
    logic             sign_q;
    logic             sign_r;
    logic             accept;
    logic             dz;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   trial;
    logic             take;
`ifdef DIV_OVF_FLAG_EN
    logic             ovf_pend;
`endif

    // A new request is taken in IDLE and also in DONE, allowing back-to-back operations.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign dz     = (divisor == '0);

    // Unsigned magnitudes; -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
    assign a_abs  = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign b_abs  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

    // Shifted partial remainder for this step, and whether the divisor fits into it.
    assign trial  = {rem_reg, q_reg[WIDTH-1]};
    assign take   = (trial >= dmag);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the busy/done status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = dz ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = SIGN;
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nxt = dz ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, one restoring step per CALC cycle,
    // then sign-fix into the result registers on the way into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            dmag        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
            ovf         <= 1'b0;
            ovf_pend    <= 1'b0;
`endif
        end else if (accept) begin
            sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r  <= dividend[WIDTH-1];
            q_reg   <= a_abs;
            rem_reg <= '0;
            dmag    <= {1'b0, b_abs};
            cnt     <= CW'(WIDTH - 1);
`ifdef DIV_OVF_FLAG_EN
            ovf      <= 1'b0;
            ovf_pend <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
            // Divide by zero skips CALC/SIGN and publishes results straight away.
            if (dz) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            rem_reg <= take ? WIDTH'(trial - dmag) : trial[WIDTH-1:0];
            q_reg   <= {q_reg[WIDTH-2:0], take};
            cnt     <= cnt - 1'b1;
        end else if (state == SIGN) begin
            // Negation wraps naturally, so -2^(W-1) / -1 yields -2^(W-1).
            quotient    <= sign_q ? -q_reg : q_reg;
            remainder   <= sign_r ? -rem_reg : rem_reg;
            div_by_zero <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
            ovf         <= ovf_pend;
`endif
        end
    end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Testbench for booth_seq_divider: directed cases, random pairs and a full
// operand sweep, checked by a scoreboard against integer / and % arithmetic.
module tb_booth_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        longint       t;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    booth_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference: plain signed integer division; done expected W+2 cycles after
    // the accepting cycle (1 for a zero divisor). t is the negedge where done shows.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input longint t0);
        exp_t e;
        int   sa;
        int   sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.t   = t0 + 10;
        end else begin
            e.q   = W'(sa / sb);
            e.r   = W'(sa % sb);
            e.dbz = 1'b0;
            e.t   = t0 + 10 * (W + 2);
        end
        return e;
    endfunction

    // Issue one division as soon as the divider is not busy (IDLE or DONE).
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_wait: busy still %0b after %0d cycles", busy, n);
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sbq.push_back(model(a, b, longint'($time)));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done at %0t: q=%0h r=%0h want no done", $time, quotient, remainder);
            end else begin
                e = sbq.pop_front();
                chk("quotient",    32'(quotient),    32'(e.q));
                chk("remainder",   32'(remainder),   32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("done_time",   32'($time),       32'(e.t));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_quotient",    32'(quotient),    0);
        chk("rst_remainder",   32'(remainder),   0);
        chk("rst_busy",        32'(busy),        0);
        chk("rst_done",        32'(done),        0);
        chk("rst_div_by_zero", 32'(div_by_zero), 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // 7 / 2 with busy checked over cycles 1..5
        do_div(4'd7, 4'd2, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("busy_window", 32'(busy), 1);
            chk("done_early",  32'(done), 0);
        end

        // sign combinations
        do_div(4'h9, 4'h2, 1'b1);
        do_div(4'h7, 4'hE, 1'b1);
        do_div(4'h9, 4'hE, 1'b1);

        // divide by zero, then a normal op clears the flag
        do_div(4'd5, 4'd0, 1'b1);
        do_div(4'd6, 4'd3, 1'b1);

        // overflow and most-negative dividend
        do_div(4'h8, 4'hF, 1'b1);
        do_div(4'h8, 4'h1, 1'b1);

        // start re-pulsed while busy is ignored; next op goes back-to-back from DONE
        do_div(4'd6, 4'd4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        do_div(4'd3, 4'd2, 1'b1);

        // reset in cycle 3 of CALC abandons the op
        do_div(4'd7, 4'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_quotient",  32'(quotient),    0);
        chk("midrst_remainder", 32'(remainder),   0);
        chk("midrst_busy",      32'(busy),        0);
        chk("midrst_done",      32'(done),        0);
        chk("midrst_dbz",       32'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_idle", 32'(busy), 0);

        // random pairs
        for (int i = 0; i < 40; i++) begin
            do_div(W'($urandom), W'($urandom_range(0, 15)), 1'b1);
        end

        // exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(W'(a), W'(b), 1'b1);
            end
        end

        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
